// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM encodings,
// digit geometry and the default idle pattern.
package display_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned DIGIT_N = 4;
    localparam int unsigned DISP_W  = DIGIT_W * DIGIT_N;

    localparam logic [DISP_W-1:0] IDLE_PATTERN_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_e;

    // Extract digit 'pos' (0 = leftmost, position A) from a packed display word.
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [DISP_W-1:0] value,
                                                     input int unsigned       pos);
        logic [DISP_W-1:0] shifted;
        shifted = value >> ((DIGIT_N - 1 - pos) * DIGIT_W);
        return shifted[DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/seg_display_arbiter_hold_timer.sv
// Minimum-hold timer: counts cycles since the current owner took the display,
// saturating at HOLD_CYCLES-1 so a long-held grant never wraps back to "fresh".
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned      CNT_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up while enabled until saturated.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments for state so every register samples pre-edge values.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing the 4-digit seven-segment display between two
// requesters. A grant is held for at least HOLD_CYCLES before the other side
// may preempt it; a voluntary release hands over immediately.
module seg_display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned       HOLD_CYCLES  = 25_000_000,
    parameter logic [DISP_W-1:0] IDLE_PATTERN = IDLE_PATTERN_DEFAULT
) (
    input  logic               clk_25mhz,
    input  logic               reset,
    input  logic               req_a,
    input  logic [DISP_W-1:0]  value_a,
    input  logic               req_b,
    input  logic [DISP_W-1:0]  value_b,
    output logic               grant_a,
    output logic               grant_b,
    output logic               switch_p,
    output logic [DIGIT_W-1:0] displayA,
    output logic [DIGIT_W-1:0] displayB,
    output logic [DIGIT_W-1:0] displayC,
    output logic [DIGIT_W-1:0] displayD
);

    state_e             state_q, state_d;
    state_e             last_q, last_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic               grant_a_q, grant_b_q, switch_q;
    logic               hold_expired;
    logic               entering_own;

    // Next owner: releases hand over at once, preemption only after the hold expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_a && (!req_b || (last_q == ST_OWN_B))) begin
                    state_d = ST_OWN_A;
                end else if (req_b) begin
                    state_d = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!req_a) begin
                    state_d = req_b ? ST_OWN_B : ST_IDLE;
                end else if (req_b && hold_expired) begin
                    state_d = ST_OWN_B;
                end
            end
            ST_OWN_B: begin
                if (!req_b) begin
                    state_d = req_a ? ST_OWN_A : ST_IDLE;
                end else if (req_a && hold_expired) begin
                    state_d = ST_OWN_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Display word and round-robin memory follow the owner being entered.
    always_comb begin
        last_d = last_q;
        disp_d = IDLE_PATTERN;
        case (state_d)
            ST_OWN_A: begin
                disp_d = value_a;
                last_d = ST_OWN_A;
            end
            ST_OWN_B: begin
                disp_d = value_b;
                last_d = ST_OWN_B;
            end
            default: disp_d = IDLE_PATTERN;
        endcase
    end

    assign entering_own = (state_d != state_q) && (state_d != ST_IDLE);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk_i     (clk_25mhz),
        .rst_i     (reset),
        .clear_i   (entering_own),
        .enable_i  (state_q != ST_IDLE),
        .expired_o (hold_expired)
    );

    // Registered state, grants, display word and owner-change pulse.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= ST_OWN_B;
            disp_q    <= IDLE_PATTERN;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            switch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            disp_q    <= disp_d;
            grant_a_q <= (state_d == ST_OWN_A);
            grant_b_q <= (state_d == ST_OWN_B);
            switch_q  <= (state_d != state_q);
        end
    end

    assign grant_a  = grant_a_q;
    assign grant_b  = grant_b_q;
    assign switch_p = switch_q;
    assign displayA = get_digit(disp_q, 0);
    assign displayB = get_digit(disp_q, 1);
    assign displayC = get_digit(disp_q, 2);
    assign displayD = get_digit(disp_q, 3);

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: a cycle-level ownership model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_seg_display_arbiter;

    localparam int unsigned HOLD = 8;
    localparam logic [15:0] IDLE = 16'hFFFF;

    logic        clk_25mhz;
    logic        reset;
    logic        req_a, req_b;
    logic [15:0] value_a, value_b;
    logic        grant_a, grant_b, switch_p;
    logic [3:0]  displayA, displayB, displayC, displayD;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    seg_display_arbiter #(
        .HOLD_CYCLES  (HOLD),
        .IDLE_PATTERN (IDLE)
    ) dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .req_a     (req_a),
        .value_a   (value_a),
        .req_b     (req_b),
        .value_b   (value_b),
        .grant_a   (grant_a),
        .grant_b   (grant_b),
        .switch_p  (switch_p),
        .displayA  (displayA),
        .displayB  (displayB),
        .displayC  (displayC),
        .displayD  (displayD)
    );

    initial begin
        clk_25mhz = 1'b0;
        forever #20 clk_25mhz = ~clk_25mhz;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = nobody, 1 = A, 2 = B. age = cycles the current owner has held.
    int          m_owner, m_last, m_age;
    logic [15:0] m_disp;
    logic        m_switch;

    always @(posedge clk_25mhz or posedge reset) begin
        int nxt;
        if (reset) begin
            m_owner  = 0;
            m_last   = 2;
            m_age    = 0;
            m_disp   = IDLE;
            m_switch = 1'b0;
        end else begin
            nxt = m_owner;
            if (m_owner == 0) begin
                if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
                else if (req_a)     nxt = 1;
                else if (req_b)     nxt = 2;
            end else begin
                // "mine"/"other" from the current owner's point of view
                automatic logic mine  = (m_owner == 1) ? req_a : req_b;
                automatic logic other = (m_owner == 1) ? req_b : req_a;
                automatic int   oth   = 3 - m_owner;
                if (!mine)                               nxt = other ? oth : 0;
                else if (other && m_age >= int'(HOLD) - 1) nxt = oth;
            end
            m_switch = (nxt != m_owner);
            m_age    = (nxt != m_owner) ? 0 : m_age + 1;
            if (nxt != 0) m_last = nxt;
            m_owner  = nxt;
            m_disp   = (nxt == 1) ? value_a : (nxt == 2) ? value_b : IDLE;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk_25mhz) begin
        if (chk_en) begin
            check("cmp_grant_a", 32'(grant_a),  32'(m_owner == 1));
            check("cmp_grant_b", 32'(grant_b),  32'(m_owner == 2));
            check("cmp_switch",  32'(switch_p), 32'(m_switch));
            check("cmp_display", 32'({displayA, displayB, displayC, displayD}), 32'(m_disp));
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step();
        @(posedge clk_25mhz);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic ga, input logic gb,
                              input logic sw, input logic [15:0] disp);
        check({tag, "_grant_a"},  32'(grant_a),  32'(ga));
        check({tag, "_grant_b"},  32'(grant_b),  32'(gb));
        check({tag, "_switch_p"}, 32'(switch_p), 32'(sw));
        check({tag, "_display"},  32'({displayA, displayB, displayC, displayD}), 32'(disp));
    endtask

    initial begin
        reset   = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        value_a = 16'h0000;
        value_b = 16'h0000;
        #3;
        reset  = 1'b1;
        chk_en = 1'b1;
        step();
        step();
        expect_out("reset", 1'b0, 1'b0, 1'b0, 16'hFFFF);
        reset = 1'b0;
        step();
        expect_out("idle_after_reset", 1'b0, 1'b0, 1'b0, 16'hFFFF);

        // Tie after reset goes to A, then round-robin.
        req_a = 1'b1; req_b = 1'b1; value_a = 16'h1234; value_b = 16'hABCD;
        step();
        expect_out("tie_a", 1'b1, 1'b0, 1'b1, 16'h1234);
        value_a = 16'h5678;
        step();
        expect_out("track_a", 1'b1, 1'b0, 1'b0, 16'h5678);
        req_a = 1'b0;
        step();
        expect_out("rr_to_b", 1'b0, 1'b1, 1'b1, 16'hABCD);
        req_b = 1'b0;
        step();
        expect_out("release_idle", 1'b0, 1'b0, 1'b1, 16'hFFFF);
        req_a = 1'b1; req_b = 1'b1;
        step();
        expect_out("rr_to_a", 1'b1, 1'b0, 1'b1, 16'h5678);
        req_a = 1'b0; req_b = 1'b0;
        step();
        expect_out("idle2", 1'b0, 1'b0, 1'b1, 16'hFFFF);

        // Hold: B requests 2 cycles into A's grant, wins exactly 8 cycles after entry.
        req_a = 1'b1; value_a = 16'h1111;
        step();
        expect_out("hold_entry", 1'b1, 1'b0, 1'b1, 16'h1111);
        step();
        step();
        req_b = 1'b1; value_b = 16'h2222;
        for (int k = 3; k <= 7; k++) begin
            step();
            expect_out("hold_wait", 1'b1, 1'b0, 1'b0, 16'h1111);
        end
        step();
        expect_out("hold_preempt", 1'b0, 1'b1, 1'b1, 16'h2222);
        step();
        expect_out("hold_after", 1'b0, 1'b1, 1'b0, 16'h2222);
        req_a = 1'b0; req_b = 1'b0;
        step();
        expect_out("idle3", 1'b0, 1'b0, 1'b1, 16'hFFFF);

        // Early release: no hold wait.
        req_a = 1'b1; value_a = 16'h9876;
        step();
        expect_out("early_entry", 1'b1, 1'b0, 1'b1, 16'h9876);
        step();
        step();
        req_a = 1'b0;
        step();
        expect_out("early_idle", 1'b0, 1'b0, 1'b1, 16'hFFFF);

        // Simultaneous release and request: direct handover.
        req_a = 1'b1; value_a = 16'h3333;
        step();
        expect_out("swap_entry", 1'b1, 1'b0, 1'b1, 16'h3333);
        step();
        req_a = 1'b0; req_b = 1'b1; value_b = 16'h4444;
        step();
        expect_out("swap_b", 1'b0, 1'b1, 1'b1, 16'h4444);
        step();
        expect_out("swap_hold", 1'b0, 1'b1, 1'b0, 16'h4444);

        // Asynchronous reset mid-grant.
        #5;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 1'b0, 1'b0, 16'hFFFF);
        step();
        step();
        reset = 1'b0; req_b = 1'b0;
        step();
        expect_out("post_reset", 1'b0, 1'b0, 1'b0, 16'hFFFF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
